// File: rtl/mmu_cp0_regs_pkg.sv
// Shared definitions for the MMU-side CP0 register block: register select
// codes, per-register write masks and a masked-merge helper.
package mmu_cp0_regs_pkg;

  typedef enum logic [3:0] {
    MMU_REG_NONE     = 4'd0,
    MMU_REG_INDEX    = 4'd1,
    MMU_REG_RANDOM   = 4'd2,
    MMU_REG_ENTRYLO0 = 4'd3,
    MMU_REG_ENTRYLO1 = 4'd4,
    MMU_REG_CTX      = 4'd5,
    MMU_REG_PAGEMASK = 4'd6,
    MMU_REG_WIRED    = 4'd7,
    MMU_REG_ENTRYHI  = 4'd8
  } mmu_reg_e;

  // Software-writable bits; everything outside a mask is held at 0 or is hardware-only.
  localparam logic [31:0] ENTRYLO_WMASK   = 32'h3FFF_FFFF;
  localparam logic [31:0] CTX_WMASK       = 32'hFF80_0000;
  localparam logic [31:0] CTX_BADVPN2_MSK = 32'h007F_FFF0;
  localparam logic [31:0] PAGEMASK_WMASK  = 32'h1FFF_E000;
  localparam logic [31:0] ENTRYHI_WMASK   = 32'hFFFF_E0FF;
  localparam logic [31:0] ENTRYHI_VPN2    = 32'hFFFF_E000;

  // Replace the bits of old_v selected by mask with the same bits of new_v.
  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

endpackage

// File: rtl/mmu_cp0_regs_random_ctr.sv
// Random replacement counter: counts down from TLB_ENTRIES-1 towards Wired
// on each retired instruction, wrapping back to the top. Wired writes reload it.
module mmu_cp0_regs_random_ctr #(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             wired_wr,
  input  logic [IDX_W-1:0] wired,
  output logic [IDX_W-1:0] random_o
);

  localparam logic [IDX_W-1:0] TOP = IDX_W'(TLB_ENTRIES - 1);

  logic [IDX_W-1:0] random_d, random_q;

  // Next Random: Wired write reload wins over step; step wraps at/below Wired.
  always_comb begin
    random_d = random_q;
    if (wired_wr) begin
      random_d = TOP;
    end else if (step) begin
      if (random_q <= wired) random_d = TOP;
      else                   random_d = random_q - 1'b1;
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) random_q <= TOP;
    else        random_q <= random_d;
  end

  assign random_o = random_q;

endmodule

// File: rtl/mmu_cp0_regs.sv
// MMU-side CP0 register responder: holds Index, Random, EntryLo0/1, Context,
// PageMask, Wired and EntryHi; serves software reads/writes and applies
// TLBP/TLBR/exception updates, which override software writes per field.
module mmu_cp0_regs
  import mmu_cp0_regs_pkg::*;
#(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       mmu_reg,
  input  logic             readMMUReg,
  input  logic             writeMMUReg,
  input  logic [31:0]      mmu_dataIn,
  output logic [31:0]      mmu_dataOut,
  input  logic             step,
  input  logic             tlbp_done,
  input  logic             tlbp_hit,
  input  logic [IDX_W-1:0] tlbp_idx,
  input  logic             tlbr_valid,
  input  logic [31:0]      tlbr_hi,
  input  logic [31:0]      tlbr_lo0,
  input  logic [31:0]      tlbr_lo1,
  input  logic [31:0]      tlbr_mask,
  input  logic             exc_tlb,
  input  logic [31:0]      exc_vaddr,
  output logic [IDX_W-1:0] index_o,
  output logic [IDX_W-1:0] random_o,
  output logic [31:0]      entryhi_o,
  output logic [31:0]      entrylo0_o,
  output logic [31:0]      entrylo1_o,
  output logic [31:0]      pagemask_o
);

  localparam logic [31:0] IDX_WMASK = {{(32-IDX_W){1'b0}}, {IDX_W{1'b1}}};

  logic [31:0] index_d, index_q;
  logic [31:0] lo0_d, lo0_q;
  logic [31:0] lo1_d, lo1_q;
  logic [31:0] ctx_d, ctx_q;
  logic [31:0] pmask_d, pmask_q;
  logic [31:0] wired_d, wired_q;
  logic [31:0] ehi_d, ehi_q;
  logic [31:0] dout_d, dout_q;
  logic [31:0] rd_val;
  logic [31:0] badvpn2;
  logic [IDX_W-1:0] random_q;
  logic wr_index, wr_lo0, wr_lo1, wr_ctx, wr_pmask, wr_wired, wr_ehi;

  assign wr_index = writeMMUReg && (mmu_reg == MMU_REG_INDEX);
  assign wr_lo0   = writeMMUReg && (mmu_reg == MMU_REG_ENTRYLO0);
  assign wr_lo1   = writeMMUReg && (mmu_reg == MMU_REG_ENTRYLO1);
  assign wr_ctx   = writeMMUReg && (mmu_reg == MMU_REG_CTX);
  assign wr_pmask = writeMMUReg && (mmu_reg == MMU_REG_PAGEMASK);
  assign wr_wired = writeMMUReg && (mmu_reg == MMU_REG_WIRED);
  assign wr_ehi   = writeMMUReg && (mmu_reg == MMU_REG_ENTRYHI);

  // BadVPN2 lands in Context[22:4].
  assign badvpn2 = {9'b0, exc_vaddr[31:13], 4'b0};

  mmu_cp0_regs_random_ctr #(
    .TLB_ENTRIES(TLB_ENTRIES),
    .IDX_W      (IDX_W)
  ) u_random_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .step    (step),
    .wired_wr(wr_wired),
    .wired   (wired_q[IDX_W-1:0]),
    .random_o(random_q)
  );

  // Next register values: software write first, then hardware layered on top
  // (tlbp < tlbr < exception) so only the fields hardware touches are overridden.
  always_comb begin
    index_d = index_q;
    lo0_d   = lo0_q;
    lo1_d   = lo1_q;
    ctx_d   = ctx_q;
    pmask_d = pmask_q;
    wired_d = wired_q;
    ehi_d   = ehi_q;

    if (wr_index) index_d = merge(index_q, mmu_dataIn, IDX_WMASK);
    if (wr_lo0)   lo0_d   = merge(lo0_q, mmu_dataIn, ENTRYLO_WMASK);
    if (wr_lo1)   lo1_d   = merge(lo1_q, mmu_dataIn, ENTRYLO_WMASK);
    if (wr_ctx)   ctx_d   = merge(ctx_q, mmu_dataIn, CTX_WMASK);
    if (wr_pmask) pmask_d = merge(pmask_q, mmu_dataIn, PAGEMASK_WMASK);
    if (wr_wired) wired_d = merge(wired_q, mmu_dataIn, IDX_WMASK);
    if (wr_ehi)   ehi_d   = merge(ehi_q, mmu_dataIn, ENTRYHI_WMASK);

    if (tlbp_done) begin
      index_d[31] = ~tlbp_hit;
      if (tlbp_hit) index_d[IDX_W-1:0] = tlbp_idx;
    end

    if (tlbr_valid) begin
      ehi_d   = tlbr_hi   & ENTRYHI_WMASK;
      lo0_d   = tlbr_lo0  & ENTRYLO_WMASK;
      lo1_d   = tlbr_lo1  & ENTRYLO_WMASK;
      pmask_d = tlbr_mask & PAGEMASK_WMASK;
    end

    if (exc_tlb) begin
      ehi_d = merge(ehi_d, exc_vaddr, ENTRYHI_VPN2);
      ctx_d = merge(ctx_d, badvpn2, CTX_BADVPN2_MSK);
    end
  end

  // Read mux over pre-edge register contents; unused codes read 0.
  always_comb begin
    rd_val = 32'h0;
    case (mmu_reg)
      MMU_REG_INDEX:    rd_val = index_q;
      MMU_REG_RANDOM:   rd_val = {{(32-IDX_W){1'b0}}, random_q};
      MMU_REG_ENTRYLO0: rd_val = lo0_q;
      MMU_REG_ENTRYLO1: rd_val = lo1_q;
      MMU_REG_CTX:      rd_val = ctx_q;
      MMU_REG_PAGEMASK: rd_val = pmask_q;
      MMU_REG_WIRED:    rd_val = wired_q;
      MMU_REG_ENTRYHI:  rd_val = ehi_q;
      default:          rd_val = 32'h0;
    endcase
  end

  // Read data capture; a simultaneous write suppresses the read result.
  always_comb begin
    dout_d = dout_q;
    if (readMMUReg && !writeMMUReg) dout_d = rd_val;
  end

  // Architectural register state and registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q <= 32'h0;
      lo0_q   <= 32'h0;
      lo1_q   <= 32'h0;
      ctx_q   <= 32'h0;
      pmask_q <= 32'h0;
      wired_q <= 32'h0;
      ehi_q   <= 32'h0;
      dout_q  <= 32'h0;
    end else begin
      index_q <= index_d;
      lo0_q   <= lo0_d;
      lo1_q   <= lo1_d;
      ctx_q   <= ctx_d;
      pmask_q <= pmask_d;
      wired_q <= wired_d;
      ehi_q   <= ehi_d;
      dout_q  <= dout_d;
    end
  end

  assign mmu_dataOut = dout_q;
  assign index_o     = index_q[IDX_W-1:0];
  assign random_o    = random_q;
  assign entryhi_o   = ehi_q;
  assign entrylo0_o  = lo0_q;
  assign entrylo1_o  = lo1_q;
  assign pagemask_o  = pmask_q;

endmodule

// File: tb/tb_mmu_cp0_regs.sv
// Bench for mmu_cp0_regs: table of write/read-back vectors plus hand-written
// sequences for Random, TLBP, TLBR, exception priority and async reset.
module tb_mmu_cp0_regs;

  localparam int IDX_W = 4;

  localparam logic [3:0] R_NONE = 4'd0, R_INDEX = 4'd1, R_RANDOM = 4'd2,
                         R_LO0 = 4'd3, R_LO1 = 4'd4, R_CTX = 4'd5,
                         R_PMASK = 4'd6, R_WIRED = 4'd7, R_EHI = 4'd8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       mmu_reg;
  logic             readMMUReg, writeMMUReg;
  logic [31:0]      mmu_dataIn;
  logic [31:0]      mmu_dataOut;
  logic             step, tlbp_done, tlbp_hit, tlbr_valid, exc_tlb;
  logic [IDX_W-1:0] tlbp_idx;
  logic [31:0]      tlbr_hi, tlbr_lo0, tlbr_lo1, tlbr_mask, exc_vaddr;
  logic [IDX_W-1:0] index_o, random_o;
  logic [31:0]      entryhi_o, entrylo0_o, entrylo1_o, pagemask_o;

  int total = 0;
  int bad   = 0;

  mmu_cp0_regs #(.TLB_ENTRIES(16), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .mmu_reg(mmu_reg),
    .readMMUReg(readMMUReg), .writeMMUReg(writeMMUReg),
    .mmu_dataIn(mmu_dataIn), .mmu_dataOut(mmu_dataOut), .step(step),
    .tlbp_done(tlbp_done), .tlbp_hit(tlbp_hit), .tlbp_idx(tlbp_idx),
    .tlbr_valid(tlbr_valid), .tlbr_hi(tlbr_hi), .tlbr_lo0(tlbr_lo0),
    .tlbr_lo1(tlbr_lo1), .tlbr_mask(tlbr_mask), .exc_tlb(exc_tlb),
    .exc_vaddr(exc_vaddr), .index_o(index_o), .random_o(random_o),
    .entryhi_o(entryhi_o), .entrylo0_o(entrylo0_o), .entrylo1_o(entrylo1_o),
    .pagemask_o(pagemask_o)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [3:0]  sel;
    logic [31:0] din;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] sel, input logic [31:0] d);
    mmu_reg = sel; mmu_dataIn = d; writeMMUReg = 1'b1;
    cycle();
    writeMMUReg = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] sel, output logic [31:0] d);
    mmu_reg = sel; readMMUReg = 1'b1;
    cycle();
    readMMUReg = 1'b0;
    d = mmu_dataOut;
  endtask

  task automatic do_step();
    step = 1'b1;
    cycle();
    step = 1'b0;
  endtask

  logic [31:0] rd;
  logic [31:0] rnd_exp[6];

  initial begin
    rst_n = 1'b0; mmu_reg = 4'd0; readMMUReg = 1'b0; writeMMUReg = 1'b0;
    mmu_dataIn = 32'h0; step = 1'b0; tlbp_done = 1'b0; tlbp_hit = 1'b0;
    tlbp_idx = '0; tlbr_valid = 1'b0; tlbr_hi = 32'h0; tlbr_lo0 = 32'h0;
    tlbr_lo1 = 32'h0; tlbr_mask = 32'h0; exc_tlb = 1'b0; exc_vaddr = 32'h0;

    vecs[0]  = '{1'b0, R_RANDOM, 32'h0,         32'h0000_000F, "rd_random_reset"};
    vecs[1]  = '{1'b0, R_INDEX,  32'h0,         32'h0000_0000, "rd_index_reset"};
    vecs[2]  = '{1'b1, R_LO0,    32'hFFFF_FFFF, 32'h3FFF_FFFF, "wr_lo0_mask"};
    vecs[3]  = '{1'b1, R_LO1,    32'hFFFF_FFFF, 32'h3FFF_FFFF, "wr_lo1_mask"};
    vecs[4]  = '{1'b1, R_EHI,    32'hFFFF_FFFF, 32'hFFFF_E0FF, "wr_ehi_mask"};
    vecs[5]  = '{1'b1, R_PMASK,  32'hFFFF_FFFF, 32'h1FFF_E000, "wr_pmask_mask"};
    vecs[6]  = '{1'b1, R_INDEX,  32'hFFFF_FFFF, 32'h0000_000F, "wr_index_mask"};
    vecs[7]  = '{1'b1, R_CTX,    32'hFFFF_FFFF, 32'hFF80_0000, "wr_ctx_mask"};
    vecs[8]  = '{1'b1, R_RANDOM, 32'h0000_0003, 32'h0000_000F, "wr_random_ignored"};
    vecs[9]  = '{1'b1, R_WIRED,  32'hFFFF_FFF5, 32'h0000_0005, "wr_wired_mask"};
    vecs[10] = '{1'b0, R_NONE,   32'h0,         32'h0000_0000, "rd_none"};
    vecs[11] = '{1'b0, 4'd12,    32'h0,         32'h0000_0000, "rd_unused"};

    // Reset block
    repeat (3) cycle();
    chk("reset_dout", mmu_dataOut, 32'h0);
    chk("reset_random_o", {28'h0, random_o}, 32'h0000_000F);
    chk("reset_index_o", {28'h0, index_o}, 32'h0);
    chk("reset_entryhi_o", entryhi_o, 32'h0);
    rst_n = 1'b1;
    cycle();

    // Table: optional write, then read back through the registered path
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) do_write(vecs[i].sel, vecs[i].din);
      do_read(vecs[i].sel, rd);
      chk(vecs[i].name, rd, vecs[i].exp);
    end
    chk("lo0_port", entrylo0_o, 32'h3FFF_FFFF);
    chk("pmask_port", pagemask_o, 32'h1FFF_E000);

    // Random: Wired=12 then five steps
    rnd_exp[0] = 32'd15; rnd_exp[1] = 32'd14; rnd_exp[2] = 32'd13;
    rnd_exp[3] = 32'd12; rnd_exp[4] = 32'd15; rnd_exp[5] = 32'd14;
    do_step();
    do_write(R_WIRED, 32'd12);
    chk("rnd_seq0", {28'h0, random_o}, rnd_exp[0]);
    for (int i = 1; i < 6; i++) begin
      do_step();
      chk($sformatf("rnd_seq%0d", i), {28'h0, random_o}, rnd_exp[i]);
    end
    do_read(R_RANDOM, rd);
    chk("rnd_read", rd, 32'd14);
    // Wired write in the same cycle as step: reload wins
    mmu_reg = R_WIRED; mmu_dataIn = 32'd3; writeMMUReg = 1'b1; step = 1'b1;
    cycle();
    writeMMUReg = 1'b0; step = 1'b0;
    chk("rnd_wired_vs_step", {28'h0, random_o}, 32'd15);
    // Wired=15: Random pinned at 15
    do_write(R_WIRED, 32'd15);
    repeat (3) do_step();
    chk("rnd_hold_top", {28'h0, random_o}, 32'd15);

    // TLBP miss / hit
    do_write(R_INDEX, 32'h0);
    tlbp_done = 1'b1; tlbp_hit = 1'b0; tlbp_idx = 4'd9;
    cycle();
    tlbp_done = 1'b0;
    do_read(R_INDEX, rd);
    chk("tlbp_miss", rd, 32'h8000_0000);
    tlbp_done = 1'b1; tlbp_hit = 1'b1; tlbp_idx = 4'd7;
    cycle();
    tlbp_done = 1'b0;
    do_read(R_INDEX, rd);
    chk("tlbp_hit", rd, 32'h0000_0007);
    // Miss with simultaneous software write: index field takes the write
    mmu_reg = R_INDEX; mmu_dataIn = 32'd3; writeMMUReg = 1'b1;
    tlbp_done = 1'b1; tlbp_hit = 1'b0;
    cycle();
    writeMMUReg = 1'b0; tlbp_done = 1'b0;
    do_read(R_INDEX, rd);
    chk("tlbp_miss_sw", rd, 32'h8000_0003);
    // Hit with simultaneous software write: hardware index wins
    mmu_reg = R_INDEX; mmu_dataIn = 32'd5; writeMMUReg = 1'b1;
    tlbp_done = 1'b1; tlbp_hit = 1'b1; tlbp_idx = 4'd10;
    cycle();
    writeMMUReg = 1'b0; tlbp_done = 1'b0;
    chk("tlbp_hit_sw_port", {28'h0, index_o}, 32'h0000_000A);

    // TLB exception loads VPN2 into EntryHi and BadVPN2 into Context
    do_write(R_CTX, 32'hFF80_0000);
    do_write(R_EHI, 32'h0000_002A);
    exc_tlb = 1'b1; exc_vaddr = 32'h1234_5678;
    cycle();
    exc_tlb = 1'b0;
    do_read(R_EHI, rd);
    chk("exc_entryhi", rd, 32'h1234_402A);
    do_read(R_CTX, rd);
    chk("exc_context", rd, 32'hFF89_1A20);
    // Same-cycle software EntryHi=0 and exception
    mmu_reg = R_EHI; mmu_dataIn = 32'h0; writeMMUReg = 1'b1;
    exc_tlb = 1'b1; exc_vaddr = 32'hFFFF_E000;
    cycle();
    writeMMUReg = 1'b0; exc_tlb = 1'b0;
    chk("exc_vs_sw_ehi", entryhi_o, 32'hFFFF_E000);

    // TLBR load, overriding a same-cycle software EntryLo0 write
    mmu_reg = R_LO0; mmu_dataIn = 32'h0000_0001; writeMMUReg = 1'b1;
    tlbr_valid = 1'b1; tlbr_hi = 32'hABCD_FF55; tlbr_lo0 = 32'hC000_0123;
    tlbr_lo1 = 32'h1234_5678; tlbr_mask = 32'hFFFF_FFFF;
    cycle();
    writeMMUReg = 1'b0; tlbr_valid = 1'b0;
    chk("tlbr_ehi", entryhi_o, 32'hABCD_E055);
    chk("tlbr_lo0", entrylo0_o, 32'h0000_0123);
    chk("tlbr_lo1", entrylo1_o, 32'h1234_5678);
    chk("tlbr_pmask", pagemask_o, 32'h1FFF_E000);

    // Read and write together: write lands, read data unchanged
    do_read(R_LO1, rd);
    chk("rd_lo1", rd, 32'h1234_5678);
    mmu_reg = R_LO0; mmu_dataIn = 32'h0000_0ABC;
    readMMUReg = 1'b1; writeMMUReg = 1'b1;
    cycle();
    readMMUReg = 1'b0; writeMMUReg = 1'b0;
    chk("rw_dout_hold", mmu_dataOut, 32'h1234_5678);
    chk("rw_write_done", entrylo0_o, 32'h0000_0ABC);

    // Asynchronous reset mid-operation, checked before any clock edge
    do_step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_dout", mmu_dataOut, 32'h0);
    chk("async_random", {28'h0, random_o}, 32'h0000_000F);
    chk("async_index", {28'h0, index_o}, 32'h0);
    chk("async_ehi", entryhi_o, 32'h0);
    chk("async_lo0", entrylo0_o, 32'h0);
    chk("async_lo1", entrylo1_o, 32'h0);
    chk("async_pmask", pagemask_o, 32'h0);
    cycle();
    rst_n = 1'b1;
    do_read(R_CTX, rd);
    chk("post_reset_ctx", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
